// File: rtl/logic1_pkg.sv
// logic1_pkg: shared types and step equations for the logic1 sequencer.
//   SYM_W        : width of an X input symbol and of a Z output symbol
//   fsm_e        : controller states IDLE/RUN/FLUSH/DONE
//   logic1_z     : Mealy output {Z1,Z2} from symbol X and state {S1,S2}
//   logic1_next  : next state {S1',S2'}; depends on X only
package logic1_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  // x = {X1,X2}, s = {S1,S2}
  function automatic logic [SYM_W-1:0] logic1_z(input logic [SYM_W-1:0] x,
                                                input logic [1:0]       s);
    logic z1, z2;
    z1 = s[1];
    z2 = (x[1] & x[0] & ~s[0]) | (x[1] & ~x[0] & s[0]);
    return {z1, z2};
  endfunction

  function automatic logic [1:0] logic1_next(input logic [SYM_W-1:0] x);
    return {~(x[1] ^ x[0]), x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/logic1_seq_controller_if.sv
// logic1_seq_controller_if: symbol stream in, result stream out.
//   in_valid/in_x/in_ready    : X symbol handshake (producer -> controller)
//   out_valid/out_z/out_ready : {Z1,Z2} result handshake (controller -> consumer)
//   master modport: testbench / surrounding logic; slave modport: controller.
interface logic1_seq_controller_if;
  import logic1_pkg::*;

  logic             in_valid;
  logic [SYM_W-1:0] in_x;
  logic             in_ready;
  logic             out_valid;
  logic [SYM_W-1:0] out_z;
  logic             out_ready;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_z
  );

endinterface

// File: rtl/logic1_sym_fifo.sv
// logic1_sym_fifo: DEPTH x SYM_W symbol FIFO, no bypass.
//   clk/rst : clock, synchronous active-high reset
//   clr     : synchronous flush (pointers and occupancy to zero)
//   push/wdata : write when not full
//   pop/rdata  : rdata is the head entry; pop advances when not empty
//   full/empty : decoded from the registered occupancy count
module logic1_sym_fifo
  import logic1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [SYM_W-1:0] wdata,
  input  logic             pop,
  output logic [SYM_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/logic1_seq_controller.sv
// logic1_seq_controller: framed Mealy sequencer for the logic1 equations.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a frame of frame_len symbols (honoured in IDLE only)
//   frame_len  : symbol count, captured with start
//   abort      : flush FIFO, state, output register and return to IDLE
//   bus        : slave side of the symbol-in / result-out handshakes
//   busy       : high in RUN and FLUSH
//   done       : one-cycle pulse at frame completion
//   state_q    : registered {S1,S2}
module logic1_seq_controller
  import logic1_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        frame_len,
  input  logic                    abort,
  logic1_seq_controller_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_q
);

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       state_d;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_z_q, out_z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fifo_full, fifo_empty;
  logic [SYM_W-1:0] fifo_rdata;
  logic             push, pop, out_free;

  // in_ready comes from registered occupancy only, so a full FIFO never
  // accepts even if a pop is happening in the same cycle.
  assign bus.in_ready = !fifo_full && !abort;
  assign push         = bus.in_valid && bus.in_ready;
  assign out_free     = !out_valid_q || bus.out_ready;
  assign pop          = (fsm_q == RUN) && !fifo_empty && out_free && !abort;

  logic1_sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .push  (push),
    .wdata (bus.in_x),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    fsm_d       = fsm_q;
    rem_d       = rem_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;

    // Drain first; a pop below overrides and keeps out_valid high.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            fsm_d   = RUN;
            rem_d   = frame_len;
            state_d = 2'b00;
          end else begin
            fsm_d = DONE;
          end
        end
      end
      RUN: begin
        if (pop) begin
          out_z_d     = logic1_z(fifo_rdata, state_q);
          out_valid_d = 1'b1;
          state_d     = logic1_next(fifo_rdata);
          rem_d       = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) fsm_d = FLUSH;
        end
      end
      FLUSH: begin
        // Frame ends once the last result has been (or is being) taken.
        if (out_free) fsm_d = DONE;
      end
      DONE: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase

    if (abort) begin
      fsm_d       = IDLE;
      rem_d       = '0;
      state_d     = 2'b00;
      out_valid_d = 1'b0;
      out_z_d     = '0;
    end

    busy_d = (fsm_d == RUN) || (fsm_d == FLUSH);
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rem_q       <= '0;
      state_q     <= 2'b00;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rem_q       <= rem_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_z     = out_z_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_logic1_seq_controller.sv
module tb_logic1_seq_controller;
  import logic1_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic       busy, done;
  logic [1:0] state_q;

  logic1_seq_controller_if ifc ();

  logic1_seq_controller #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .abort     (abort),
    .bus       (ifc),
    .busy      (busy),
    .done      (done),
    .state_q   (state_q)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         vectors = 0;
  int         errs = 0;
  int         done_cnt = 0;
  int         last_acc_cyc = 0;
  logic [1:0] outs[$];
  int         out_cyc[$];
  logic [1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.out_valid && ifc.out_ready) begin
        outs.push_back(ifc.out_z);
        out_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [1:0] x);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    ifc.in_valid = 1'b1;
    ifc.in_x     = x;
    do begin
      @(negedge clk);
      acc = ifc.in_ready;
      if (acc) last_acc_cyc = cyc;
      tick();
      n++;
    end while (!acc && n < 60);
    ifc.in_valid = 1'b0;
    chk({tag, "_push_acc"}, acc, 1'b1);
  endtask

  task automatic set_start(input logic [7:0] len);
    start     = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_state);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_state"}, state_q, exp_state);
    tick();
  endtask

  task automatic check_outs(input string tag, input logic [1:0] exp[$]);
    int m;
    chk({tag, "_nout"}, outs.size(), exp.size());
    m = (outs.size() < exp.size()) ? outs.size() : exp.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_out%0d", tag, i), outs[i], exp[i]);
  endtask

  initial begin
    int first_push_cyc;
    ifc.in_valid  = 1'b0;
    ifc.in_x      = 2'b00;
    ifc.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", state_q, 2'b00);
    chk("rst_out_valid", ifc.out_valid, 1'b0);
    chk("rst_out_z", ifc.out_z, 2'b00);
    chk("rst_in_ready", ifc.in_ready, 1'b1);
    tick();

    // 1: preload 11,10,01,00, frame_len=4
    ifc.out_ready = 1'b1;
    push("t1", 2'b11); push("t1", 2'b10); push("t1", 2'b01); push("t1", 2'b00);
    outs.delete(); done_cnt = 0;
    set_start(8'd4);
    @(negedge clk);
    chk("t1_busy", busy, 1'b1);
    wait_done("t1", 2'b10);
    tick(); tick();
    exp_q = '{2'b01, 2'b10, 2'b00, 2'b00};
    check_outs("t1", exp_q);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: 10,10, frame_len=2
    push("t2", 2'b10); push("t2", 2'b10);
    outs.delete(); done_cnt = 0;
    set_start(8'd2);
    wait_done("t2", 2'b01);
    exp_q = '{2'b00, 2'b01};
    check_outs("t2", exp_q);

    // 3: consumer stalls mid-frame; FIFO fills behind the held result
    outs.delete(); done_cnt = 0;
    ifc.out_ready = 1'b0;
    set_start(8'd6);
    push("t3", 2'b11); push("t3", 2'b01); push("t3", 2'b10);
    push("t3", 2'b00); push("t3", 2'b11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t3_in_ready_full%0d", k), ifc.in_ready, 1'b0);
      chk($sformatf("t3_hold_valid%0d", k), ifc.out_valid, 1'b1);
      chk($sformatf("t3_hold_z%0d", k), ifc.out_z, 2'b01);
      tick();
    end
    ifc.out_ready = 1'b1;
    push("t3", 2'b10);
    wait_done("t3", 2'b01);
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
    check_outs("t3", exp_q);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: abort on third RUN cycle of an 8-symbol frame
    push("t4", 2'b11); push("t4", 2'b11); push("t4", 2'b11); push("t4", 2'b11);
    done_cnt = 0;
    set_start(8'd8);
    tick(); tick();
    abort = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_x     = 2'b00;
    @(negedge clk);
    chk("t4_in_ready_abort", ifc.in_ready, 1'b0);
    tick();
    abort = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy", busy, 1'b0);
    chk("t4_out_valid", ifc.out_valid, 1'b0);
    chk("t4_state", state_q, 2'b00);
    chk("t4_done", done, 1'b0);
    tick(); tick(); tick();
    chk("t4_no_done", done_cnt, 0);
    // Stale 11 symbols would yield 01; a flushed FIFO yields 00 from X=10.
    outs.delete();
    push("t4b", 2'b10);
    set_start(8'd1);
    wait_done("t4b", 2'b01);
    exp_q = '{2'b00};
    check_outs("t4b", exp_q);

    // 5: zero-length frame consumes nothing, FIFO contents survive
    push("t5", 2'b11); push("t5", 2'b10);
    outs.delete(); done_cnt = 0;
    set_start(8'd0);
    @(negedge clk);
    chk("t5_done_pulse", done, 1'b1);
    chk("t5_busy", busy, 1'b0);
    tick();
    @(negedge clk);
    chk("t5_done_low", done, 1'b0);
    chk("t5_no_pop", outs.size(), 0);
    tick();
    set_start(8'd2);
    wait_done("t5b", 2'b01);
    exp_q = '{2'b01, 2'b10};
    check_outs("t5b", exp_q);

    // 6: 20 symbols streamed; start pulsed mid-frame must be ignored
    outs.delete(); out_cyc.delete(); done_cnt = 0;
    set_start(8'd20);
    first_push_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] x;
      case (i % 4)
        0: x = 2'b11;
        1: x = 2'b10;
        2: x = 2'b01;
        default: x = 2'b00;
      endcase
      if (i == 10) begin
        start     = 1'b1;
        frame_len = 8'd3;
      end
      push("t6", x);
      start = 1'b0;
      if (i == 0) first_push_cyc = last_acc_cyc;
    end
    wait_done("t6", 2'b10);
    tick(); tick();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0: exp_q.push_back((i == 0) ? 2'b01 : 2'b11);
        1: exp_q.push_back(2'b10);
        default: exp_q.push_back(2'b00);
      endcase
    end
    check_outs("t6", exp_q);
    chk("t6_done_cnt", done_cnt, 1);
    if (out_cyc.size() == 20) begin
      chk("t6_latency", out_cyc[0] - first_push_cyc, 2);
      chk("t6_throughput", out_cyc[19] - out_cyc[0], 19);
    end else begin
      chk("t6_ncyc", out_cyc.size(), 20);
    end
    chk("t6_idle_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
